// File: rtl/block_scheduler_pkg.sv
// rtl/block_scheduler_pkg.sv - shared types and defaults for the falling-block scheduler
// Contents: scheduler state enum, default slot count, lane X centres, bottom screen row.
package block_scheduler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DELAY,
      ST_SPAWN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   localparam int         NUM_SLOTS_DEF = 4;
   localparam logic [9:0] LANE_X0_DEF   = 10'd80;
   localparam logic [9:0] LANE_X1_DEF   = 10'd240;
   localparam logic [9:0] LANE_X2_DEF   = 10'd400;
   localparam logic [9:0] LANE_X3_DEF   = 10'd560;
   localparam int         Y_MAX_DEF     = 479;

endpackage

// File: rtl/block_scheduler_if.sv
// rtl/block_scheduler_if.sv - pattern source and block slot signal bundle
// Pattern group: pattern_valid/lane/delay/last from the source, pattern_rd pop strobe back.
// Slot group: slot_y from the block instances; slot_restart, slot_x, slot_ready to them.
// master = scheduler side, slave = pattern source / block side.
interface block_scheduler_if
   import block_scheduler_pkg::*;
#(
   parameter int NUM_SLOTS = NUM_SLOTS_DEF
) ();

   logic                       pattern_valid;
   logic [1:0]                 pattern_lane;
   logic [7:0]                 pattern_delay;
   logic                       pattern_last;
   logic                       pattern_rd;
   logic [NUM_SLOTS-1:0][9:0]  slot_y;
   logic [NUM_SLOTS-1:0]       slot_restart;
   logic [NUM_SLOTS-1:0][9:0]  slot_x;
   logic [NUM_SLOTS-1:0]       slot_ready;

   modport master (
      input  pattern_valid, pattern_lane, pattern_delay, pattern_last, slot_y,
      output pattern_rd, slot_restart, slot_x, slot_ready
   );

   modport slave (
      output pattern_valid, pattern_lane, pattern_delay, pattern_last, slot_y,
      input  pattern_rd, slot_restart, slot_x, slot_ready
   );

endinterface

// File: rtl/block_scheduler_slot_alloc.sv
// rtl/block_scheduler_slot_alloc.sv - lowest-index free slot picker
// Ports: active (in, one bit per slot), idx (out, lowest slot with active=0),
// found (out, high when any slot is free; idx is 0 otherwise).
module block_scheduler_slot_alloc #(
   parameter int NUM_SLOTS = 4,
   parameter int IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
   input  logic [NUM_SLOTS-1:0] active,
   output logic [IDX_W-1:0]     idx,
   output logic                 found
);

   // Scan from the top down so the last hit written is the lowest index.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!active[i]) begin
            idx   = IDX_W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/block_scheduler.sv
// rtl/block_scheduler.sv - sequences pattern entries into a pool of falling-block slots
// Ports: frame_clk (in), rst_n (in, sync active-low), start/pause (in, levels),
// bus (block_scheduler_if.master: pattern pop interface and per-slot control),
// busy/done (out, state flags), miss_cnt (out, saturating count of dropped entries).
module block_scheduler
   import block_scheduler_pkg::*;
#(
   parameter int         NUM_SLOTS = NUM_SLOTS_DEF,
   parameter logic [9:0] LANE_X0   = LANE_X0_DEF,
   parameter logic [9:0] LANE_X1   = LANE_X1_DEF,
   parameter logic [9:0] LANE_X2   = LANE_X2_DEF,
   parameter logic [9:0] LANE_X3   = LANE_X3_DEF,
   parameter int         Y_MAX     = Y_MAX_DEF
) (
   input  logic                frame_clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                pause,
   block_scheduler_if.master   bus,
   output logic                busy,
   output logic                done,
   output logic [7:0]          miss_cnt
);

   localparam int         IDX_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam logic [9:0] Y_LIMIT = 10'(Y_MAX);

   state_t                     state_q, state_d;
   logic [1:0]                 lane_q;
   logic [7:0]                 delay_q;
   logic                       last_q;
   logic [NUM_SLOTS-1:0]       active_q, active_d;
   logic [NUM_SLOTS-1:0]       ready_q;
   logic [NUM_SLOTS-1:0]       spawn_vec;
   logic [NUM_SLOTS-1:0][9:0]  x_q;
   logic [7:0]                 miss_q;
   logic [IDX_W-1:0]           free_idx;
   logic                       free_found;
   logic                       pop, do_spawn, do_miss;
   logic [9:0]                 lane_x;

   block_scheduler_slot_alloc #(
      .NUM_SLOTS (NUM_SLOTS),
      .IDX_W     (IDX_W)
   ) u_slot_alloc (
      .active (active_q),
      .idx    (free_idx),
      .found  (free_found)
   );

   // Lanes without a matching slot (small configurations) fall back to lane 0.
   always_comb begin
      case (lane_q)
         2'd0:    lane_x = LANE_X0;
         2'd1:    lane_x = LANE_X1;
         2'd2:    lane_x = LANE_X2;
         default: lane_x = LANE_X3;
      endcase
      if (32'(lane_q) >= NUM_SLOTS) lane_x = LANE_X0;
   end

   always_comb begin
      state_d  = state_q;
      pop      = 1'b0;
      do_spawn = 1'b0;
      do_miss  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (bus.pattern_valid && !pause) begin
               pop     = 1'b1;
               state_d = ST_DELAY;
            end
         end
         ST_DELAY: begin
            // The final decrement (1 -> 0) and the zero-delay case both leave
            // immediately, so DELAY lasts max(delay, 1) unpaused frames.
            if (delay_q == 8'd0 || (delay_q == 8'd1 && !pause)) state_d = ST_SPAWN;
         end
         ST_SPAWN: begin
            if (!pause) begin
               do_spawn = free_found;
               do_miss  = !free_found;
               state_d  = last_q ? ST_DRAIN : ST_FETCH;
            end
         end
         ST_DRAIN: begin
            if (active_q == '0) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (start) state_d = ST_FETCH;
         end
         default: state_d = ST_IDLE;
      endcase
      // A reset edge must not pop the source or start a spawn.
      if (!rst_n) begin
         pop      = 1'b0;
         do_spawn = 1'b0;
         do_miss  = 1'b0;
      end
   end

   // Slot set on spawn wins over the off-screen clear; the picker reads the
   // registered active bits, so a slot clearing this cycle is not yet free.
   always_comb begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
         spawn_vec[i] = do_spawn && (free_idx == IDX_W'(i));
         active_d[i]  = active_q[i];
         if (spawn_vec[i])               active_d[i] = 1'b1;
         else if (bus.slot_y[i] > Y_LIMIT) active_d[i] = 1'b0;
      end
   end

   always_ff @(posedge frame_clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         lane_q   <= 2'd0;
         delay_q  <= 8'd0;
         last_q   <= 1'b0;
         active_q <= '0;
         ready_q  <= '0;
         x_q      <= {NUM_SLOTS{LANE_X0}};
         miss_q   <= 8'd0;
      end else begin
         state_q  <= state_d;
         active_q <= active_d;
         // The restart cycle of a slot always has active_q=0, so ready can never
         // be high together with its restart pulse.
         ready_q  <= active_d & {NUM_SLOTS{~pause}};
         if (pop) begin
            lane_q  <= bus.pattern_lane;
            delay_q <= bus.pattern_delay;
            last_q  <= bus.pattern_last;
         end else if (state_q == ST_DELAY && !pause && delay_q != 8'd0) begin
            delay_q <= delay_q - 8'd1;
         end
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (spawn_vec[i]) x_q[i] <= lane_x;
         end
         if (state_q == ST_DONE && start)     miss_q <= 8'd0;
         else if (do_miss && miss_q != 8'hff) miss_q <= miss_q + 8'd1;
      end
   end

   assign bus.pattern_rd   = pop;
   assign bus.slot_restart = rst_n ? spawn_vec : '1;
   assign bus.slot_x       = x_q;
   assign bus.slot_ready   = ready_q;
   assign busy             = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done             = (state_q == ST_DONE);
   assign miss_cnt         = miss_q;

endmodule
